inc_alu_scheduler: RTL and testbench

//  Shares one external 8-bit incrementer datapath (numa -> outa = numa+1) among
//  NUM_REQ requesters. Round-robin arbitration, operand latching, result capture,

---
 rtl/inc_alu_scheduler_if.sv | 26 ++
 rtl/inc_alu_scheduler.sv | 112 +++++++++++
 tb/tb_inc_alu_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inc_alu_scheduler_if.sv
// Request/response bundle between client logic and inc_alu_scheduler.
// master = client side (requesters and response consumer), slave = scheduler.
interface inc_alu_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_ovf;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
    );
endinterface

// File: rtl/inc_alu_scheduler.sv
// Round-robin scheduler sharing one external incrementer among NUM_REQ requesters.
// Optional INC_ALU_SAT_EN: saturate all-ones operands instead of wrapping to zero.
module inc_alu_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    inc_alu_scheduler_if.slave  bus,
    output logic [DATA_W-1:0]   alu_numa,
    input  logic [DATA_W-1:0]   alu_outa,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    // Handshake: a request transfers on the rising edge where req_valid[i] & req_ready[i];
    // a response transfers on the edge where rsp_valid & rsp_ready. rsp_* hold while stalled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   id_q;
    logic              ovf_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_ovf_q;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] exec_result;
    logic              accept;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign operand = bus.req_data[int'(winner)*DATA_W +: DATA_W];

    // Grant is suppressed while rst is high, since the async reset forces IDLE.
    assign bus.req_ready = (state == IDLE && found && !rst) ? (NUM_REQ'(1) << winner) : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

`ifdef INC_ALU_SAT_EN
    assign exec_result = ovf_q ? {DATA_W{1'b1}} : alu_outa;
`else
    assign exec_result = alu_outa;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            alu_numa    <= '0;
            id_q        <= '0;
            ovf_q       <= 1'b0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_numa   <= operand;
                        id_q       <= winner;
                        ovf_q      <= (operand == {DATA_W{1'b1}});
                        last_grant <= winner;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= exec_result;
                    rsp_id_q    <= id_q;
                    rsp_ovf_q   <= ovf_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_inc_alu_scheduler.sv
// Self-checking bench for inc_alu_scheduler: directed scenarios plus a randomized
// run compared against a transaction-level round-robin/incrementer model.
module tb_inc_alu_scheduler;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] alu_numa;
    logic [7:0] alu_outa;
    logic       busy;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    inc_alu_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus_i ();

    inc_alu_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_i.slave),
        .alu_numa  (alu_numa),
        .alu_outa  (alu_outa),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // The external incrementer the scheduler drives.
    assign alu_outa = alu_numa + 8'd1;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic r);
        bus_i.req_valid = v;
        bus_i.req_data  = d;
        bus_i.rsp_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 32'h0, 1'b1);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_result(input logic [7:0] op);
`ifdef INC_ALU_SAT_EN
        if (op == 8'hFF) return 8'hFF;
`endif
        return 8'((int'(op) + 1) % 256);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, 32'hFFFFFFFF, 1'b1);
        step();
        step();
        checks++; if (bus_i.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus_i.req_ready); end
        checks++; if (bus_i.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus_i.rsp_valid); end
        checks++; if ({bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data} !== 11'h0) begin failures++; $display("FAIL reset_rsp_fields got=%h exp=000", {bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (alu_numa !== 8'h00) begin failures++; $display("FAIL reset_numa got=%h exp=00", alu_numa); end
        rst = 1'b0;
        #1;
        checks++; if (bus_i.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus_i.req_ready); end
        drive(4'b0000, 32'h0, 1'b1);
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0001, 32'h00000041, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0001) begin failures++; $display("FAIL t1_ready got=%b exp=0001", bus_i.req_ready); end
        step();
        drive(4'b0000, 32'h00000099, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0000) begin failures++; $display("FAIL t1_ready_exec got=%b exp=0000", bus_i.req_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
        checks++; if (alu_numa !== 8'h41) begin failures++; $display("FAIL t1_numa got=%h exp=41", alu_numa); end
        checks++; if (bus_i.rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_early_rsp got=%b exp=0", bus_i.rsp_valid); end
        step();
        checks++; if (bus_i.rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid got=%b exp=1", bus_i.rsp_valid); end
        checks++; if ({bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data} !== {1'b0, 2'd0, 8'h42}) begin failures++; $display("FAIL t1_rsp got=%h exp=%h", {bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data}, {1'b0, 2'd0, 8'h42}); end
        step();
        checks++; if ({bus_i.rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL t1_done got=%b exp=00", {bus_i.rsp_valid, busy}); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last_cyc = 0;
        do_reset();
        drive(4'b1111, 32'h30201000, 1'b1);
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (bus_i.rsp_valid === 1'b1) begin
                checks++; if (bus_i.rsp_id !== 2'(n % 4)) begin failures++; $display("FAIL t2_id[%0d] got=%0d exp=%0d", n, bus_i.rsp_id, n % 4); end
                checks++; if (bus_i.rsp_data !== 8'(16 * (n % 4) + 1)) begin failures++; $display("FAIL t2_data[%0d] got=%h exp=%h", n, bus_i.rsp_data, 8'(16 * (n % 4) + 1)); end
                if (n > 0) begin
                    checks++; if (cyc - last_cyc != 3) begin failures++; $display("FAIL t2_interval[%0d] got=%0d exp=3", n, cyc - last_cyc); end
                end
                last_cyc = cyc;
                n++;
            end
            step();
        end
        checks++; if (n != 5) begin failures++; $display("FAIL t2_count got=%0d exp=5", n); end
        drive(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'b0100, 32'h00FF0000, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0100) begin failures++; $display("FAIL t3_ready got=%b exp=0100", bus_i.req_ready); end
        step();
        drive(4'b0000, 32'h0, 1'b1);
        step();
`ifdef INC_ALU_SAT_EN
        checks++; if (bus_i.rsp_data !== 8'hFF) begin failures++; $display("FAIL t3_data got=%h exp=ff", bus_i.rsp_data); end
`else
        checks++; if (bus_i.rsp_data !== 8'h00) begin failures++; $display("FAIL t3_data got=%h exp=00", bus_i.rsp_data); end
`endif
        checks++; if ({bus_i.rsp_valid, bus_i.rsp_ovf, bus_i.rsp_id} !== 4'b1110) begin failures++; $display("FAIL t3_flags got=%b exp=1110", {bus_i.rsp_valid, bus_i.rsp_ovf, bus_i.rsp_id}); end
    endtask

    task automatic test_backpressure();
        logic [10:0] held;
        int waited = 0;
        do_reset();
        drive(4'b1111, 32'h44332211, 1'b0);
        while (bus_i.rsp_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++; if (bus_i.rsp_valid !== 1'b1) begin failures++; $display("FAIL t4_rsp_timeout got=%b exp=1", bus_i.rsp_valid); end
        held = {bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data};
        checks++; if (held !== {1'b0, 2'd0, 8'h12}) begin failures++; $display("FAIL t4_first got=%h exp=%h", held, {1'b0, 2'd0, 8'h12}); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({bus_i.rsp_valid, bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data} !== {1'b1, held}) begin failures++; $display("FAIL t4_hold[%0d] got=%h exp=%h", i, {bus_i.rsp_valid, bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data}, {1'b1, held}); end
            checks++; if ({bus_i.req_ready, busy} !== 5'b00001) begin failures++; $display("FAIL t4_stall[%0d] got=%b exp=00001", i, {bus_i.req_ready, busy}); end
        end
        drive(4'b1111, 32'h44332211, 1'b1);
        step();
        checks++; if (bus_i.rsp_valid !== 1'b0) begin failures++; $display("FAIL t4_release got=%b exp=0", bus_i.rsp_valid); end
        checks++; if (bus_i.req_ready !== 4'b0010) begin failures++; $display("FAIL t4_next_grant got=%b exp=0010", bus_i.req_ready); end
        drive(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive(4'b0001, 32'h00000033, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0001) begin failures++; $display("FAIL t5_ready got=%b exp=0001", bus_i.req_ready); end
        step();
        drive(4'b1111, 32'h0, 1'b1);
        checks++; if ({busy, alu_numa} !== {1'b1, 8'h33}) begin failures++; $display("FAIL t5_exec got=%h exp=%h", {busy, alu_numa}, {1'b1, 8'h33}); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, alu_numa, bus_i.rsp_valid, bus_i.req_ready} !== 14'h0) begin failures++; $display("FAIL t5_async got=%h exp=0000", {busy, alu_numa, bus_i.rsp_valid, bus_i.req_ready}); end
        step();
        step();
        checks++; if ({bus_i.rsp_valid, bus_i.req_ready} !== 5'b0) begin failures++; $display("FAIL t5_in_reset got=%b exp=00000", {bus_i.rsp_valid, bus_i.req_ready}); end
        drive(4'b0000, 32'h0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_i.rsp_valid !== 1'b0) begin failures++; $display("FAIL t5_no_rsp[%0d] got=%b exp=0", i, bus_i.rsp_valid); end
        end
        drive(4'b1111, 32'h0, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0001) begin failures++; $display("FAIL t5_first_grant got=%b exp=0001", bus_i.req_ready); end
        drive(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_skip_idle();
        do_reset();
        drive(4'b0010, 32'h0, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b0010) begin failures++; $display("FAIL t6_setup got=%b exp=0010", bus_i.req_ready); end
        step();
        drive(4'b0000, 32'h0, 1'b1);
        step();
        step();
        drive(4'b1010, 32'h0, 1'b1);
        checks++; if (bus_i.req_ready !== 4'b1000) begin failures++; $display("FAIL t6_grant3 got=%b exp=1000", bus_i.req_ready); end
        step();
        step();
        step();
        checks++; if (bus_i.req_ready !== 4'b0010) begin failures++; $display("FAIL t6_grant1 got=%b exp=0010", bus_i.req_ready); end
        drive(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        int last = NUM_REQ - 1;
        int in_flight = 0;
        int age = 0;
        int w;
        int rsp_seen = 0;
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        logic        exp_rv;
        logic [3:0]  exp_ready;
        logic [7:0]  op;
        do_reset();
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v = 4'b0000;
            d = $urandom;
            for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(0, 5) == 0) d[i*8 +: 8] = 8'hFF;
            r = ($urandom_range(0, 2) != 0);
            drive(v, d, r);

            exp_rv = (in_flight != 0) && (age >= 2);
            checks++; if (bus_i.rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus_i.rsp_valid, exp_rv); end
            w = (in_flight != 0) ? -1 : model_winner(v, last);
            exp_ready = (w < 0) ? 4'b0000 : 4'(1 << w);
            checks++; if (bus_i.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, bus_i.req_ready, exp_ready); end

            if (exp_rv && exp_q.size() > 0) begin
                checks++; if ({bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data} !== exp_q[0]) begin failures++; $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", cyc, {bus_i.rsp_ovf, bus_i.rsp_id, bus_i.rsp_data}, exp_q[0]); end
                if (r) begin
                    void'(exp_q.pop_front());
                    in_flight = 0;
                    rsp_seen++;
                end
            end
            if (w >= 0) begin
                op = d[w*8 +: 8];
                exp_q.push_back({(op == 8'hFF), 2'(w), model_result(op)});
                last = w;
                in_flight = 1;
                age = 0;
            end
            step();
            if (in_flight != 0) age++;
        end
        checks++; if (rsp_seen < 50) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=50", rsp_seen); end
        drive(4'b0000, 32'h0, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus_i.req_valid = '0;
        bus_i.req_data  = '0;
        bus_i.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_skip_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
